// File: rtl/perceptron_layer_trainer_pkg.sv
// Sizes, state codes and signed Q8.8 fixed-point (sfp) helpers shared by the perceptron layer trainer.
package perceptron_layer_trainer_pkg;

  localparam int unsigned SIZE     = 2;
  localparam int unsigned NUM      = 4;
  localparam int unsigned OUTPUTS  = 2;
  localparam int unsigned EPOCH_W  = 16;
  localparam int unsigned SFP_W    = 16;
  localparam int unsigned SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp SFP_ONE = 16'sh0100;

  typedef enum logic [1:0] {
    ACT_STEP   = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LINEAR = 2'd2
  } act_func;

  typedef logic [2:0] layer_state;
  localparam layer_state ST_IDLE      = 3'd0;
  localparam layer_state ST_MAC       = 3'd1;
  localparam layer_state ST_ERR       = 3'd2;
  localparam layer_state ST_UPD       = 3'd3;
  localparam layer_state ST_EPOCH_END = 3'd4;
  localparam layer_state ST_DONE      = 3'd5;

  // All sfp arithmetic wraps at SFP_W bits; no width growth.
  function automatic sfp sfp_add(input sfp a, input sfp b);
    return a + b;
  endfunction

  function automatic sfp sfp_sub(input sfp a, input sfp b);
    return a - b;
  endfunction

  function automatic sfp sfp_mul(input sfp a, input sfp b);
    logic signed [2*SFP_W-1:0] p;
    p = (2*SFP_W)'(a) * (2*SFP_W)'(b);
    return SFP_W'(p >>> SFP_FRAC);
  endfunction

  function automatic logic sfp_is_zero(input sfp a);
    return (a == '0);
  endfunction

  function automatic sfp sfp_act(input act_func f, input sfp x);
    sfp r;
    case (f)
      ACT_STEP: r = (x > 0) ? SFP_ONE : '0;
      ACT_RELU: r = x[SFP_W-1] ? '0 : x;
      default:  r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/perceptron_layer_trainer_sfp_mac_unit.sv
// Sequential sfp multiply-accumulate: one product per enabled cycle, optionally seeded from a bias.
module perceptron_layer_trainer_sfp_mac_unit
  import perceptron_layer_trainer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load_bias,
  input  logic en,
  input  sfp   bias,
  input  sfp   w,
  input  sfp   x,
  output sfp   acc
);

  sfp acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sfp_add(load_bias ? bias : acc_q, sfp_mul(w, x));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/perceptron_layer_trainer.sv
// Multi-output single-layer perceptron: shared sequential MAC trainer plus combinational inference.
module perceptron_layer_trainer
  import perceptron_layer_trainer_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             clear_weights,
  input  logic [EPOCH_W-1:0]               epochs,
  input  sfp                               learning_rate,
  input  act_func                          activation,
  input  sfp   [NUM-1:0][SIZE-1:0]         train_values,
  input  sfp   [NUM-1:0][OUTPUTS-1:0]      expected,
  input  sfp   [SIZE-1:0]                  values,
  output sfp   [OUTPUTS-1:0]               prediction,
  output logic                             busy,
  output logic                             done,
  output logic                             converged,
  output logic [EPOCH_W-1:0]               epochs_run
);

  localparam int unsigned S_W    = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned J_W    = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
  localparam int unsigned E_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned ERRC_W = $clog2(NUM*OUTPUTS+1);

  layer_state          state_q, state_d;
  logic [S_W-1:0]      s_q, s_d;
  logic [J_W-1:0]      j_q, j_d;
  logic [E_W-1:0]      e_q, e_d;
  logic [ERRC_W-1:0]   err_cnt_q, err_cnt_d;
  sfp                  err_q, err_d;
  sfp                  lr_q, lr_d;
  logic [EPOCH_W-1:0]  epochs_lim_q, epochs_lim_d;
  logic [EPOCH_W-1:0]  epochs_run_q, epochs_run_d;
  logic                conv_q, conv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  sfp                  w_q [OUTPUTS][SIZE];
  sfp                  w_d [OUTPUTS][SIZE];
  sfp                  b_q [OUTPUTS];
  sfp                  b_d [OUTPUTS];

  sfp   delta;
  sfp   mac_acc;
  logic mac_clr, mac_load, mac_en;

  perceptron_layer_trainer_sfp_mac_unit u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (mac_clr),
    .load_bias (mac_load),
    .en        (mac_en),
    .bias      (b_q[j_q]),
    .w         (w_q[j_q][e_q]),
    .x         (train_values[s_q][e_q]),
    .acc       (mac_acc)
  );

  // Next-state, counters and weight updates.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    j_d          = j_q;
    e_d          = e_q;
    err_cnt_d    = err_cnt_q;
    err_d        = err_q;
    lr_d         = lr_q;
    epochs_lim_d = epochs_lim_q;
    epochs_run_d = epochs_run_q;
    conv_d       = conv_q;
    w_d          = w_q;
    b_d          = b_q;
    delta        = '0;
    mac_clr      = 1'b0;
    mac_load     = 1'b0;
    mac_en       = 1'b0;
    busy_d       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done_d       = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (clear_weights) begin
          w_d = '{default: '0};
          b_d = '{default: '0};
        end else if (start) begin
          lr_d         = learning_rate;
          epochs_lim_d = epochs;
          s_d          = '0;
          j_d          = '0;
          e_d          = '0;
          err_cnt_d    = '0;
          epochs_run_d = '0;
          conv_d       = 1'b0;
          mac_clr      = 1'b1;
          state_d      = (epochs == '0) ? ST_DONE : ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en   = 1'b1;
        mac_load = (e_q == '0);
        if (e_q == E_W'(SIZE-1)) begin
          e_d     = '0;
          state_d = ST_ERR;
        end else begin
          e_d = e_q + E_W'(1);
        end
      end
      ST_ERR: begin
        err_d = sfp_sub(expected[s_q][j_q], sfp_act(activation, mac_acc));
        if (!sfp_is_zero(err_d)) begin
          err_cnt_d = err_cnt_q + ERRC_W'(1);
        end
        state_d = ST_UPD;
      end
      ST_UPD: begin
        delta = sfp_mul(lr_q, err_q);
        for (int i = 0; i < SIZE; i++) begin
          w_d[j_q][i] = sfp_add(w_q[j_q][i], sfp_mul(delta, train_values[s_q][i]));
        end
        b_d[j_q] = sfp_add(b_q[j_q], delta);
        state_d  = ST_MAC;
        if (j_q == J_W'(OUTPUTS-1)) begin
          j_d = '0;
          if (s_q == S_W'(NUM-1)) begin
            s_d     = '0;
            state_d = ST_EPOCH_END;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end else begin
          j_d = j_q + J_W'(1);
        end
      end
      ST_EPOCH_END: begin
        epochs_run_d = epochs_run_q + EPOCH_W'(1);
        if (err_cnt_q == '0) begin
          conv_d  = 1'b1;
          state_d = ST_DONE;
        end else if (epochs_run_q + EPOCH_W'(1) == epochs_lim_q) begin
          state_d = ST_DONE;
        end else begin
          err_cnt_d = '0;
          state_d   = ST_MAC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      j_q          <= '0;
      e_q          <= '0;
      err_cnt_q    <= '0;
      err_q        <= '0;
      lr_q         <= '0;
      epochs_lim_q <= '0;
      epochs_run_q <= '0;
      conv_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_q          <= '{default: '0};
      b_q          <= '{default: '0};
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      j_q          <= j_d;
      e_q          <= e_d;
      err_cnt_q    <= err_cnt_d;
      err_q        <= err_d;
      lr_q         <= lr_d;
      epochs_lim_q <= epochs_lim_d;
      epochs_run_q <= epochs_run_d;
      conv_q       <= conv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      w_q          <= w_d;
      b_q          <= b_d;
    end
  end

  // Inference always reflects the live weights, including mid-training.
  sfp pred_acc;
  always_comb begin
    pred_acc   = '0;
    prediction = '0;
    for (int j = 0; j < OUTPUTS; j++) begin
      pred_acc = b_q[j];
      for (int i = 0; i < SIZE; i++) begin
        pred_acc = sfp_add(pred_acc, sfp_mul(w_q[j][i], values[i]));
      end
      prediction[j] = sfp_act(activation, pred_acc);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign epochs_run = epochs_run_q;

endmodule

// File: tb/tb_perceptron_layer_trainer.sv
// Table-driven and randomized bench for perceptron_layer_trainer against an arithmetic reference model.
module tb_perceptron_layer_trainer;
  import perceptron_layer_trainer_pkg::*;

  localparam int LEN = NUM*OUTPUTS*(SIZE+2)+1;

  logic clk = 1'b0;
  logic rst_n, start, clear_weights;
  logic [15:0] epochs;
  sfp learning_rate;
  act_func activation;
  sfp [NUM-1:0][SIZE-1:0] train_values;
  sfp [NUM-1:0][OUTPUTS-1:0] expected;
  sfp [SIZE-1:0] values;
  sfp [OUTPUTS-1:0] prediction;
  logic busy, done, converged;
  logic [15:0] epochs_run;

  int n_vec = 0;
  int n_err = 0;

  sfp mw [OUTPUTS][SIZE];
  sfp mb [OUTPUTS];

  perceptron_layer_trainer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_weights(clear_weights),
    .epochs(epochs), .learning_rate(learning_rate), .activation(activation),
    .train_values(train_values), .expected(expected), .values(values),
    .prediction(prediction), .busy(busy), .done(done), .converged(converged),
    .epochs_run(epochs_run)
  );

  always #5 clk = ~clk;

  typedef struct {
    int      kind;
    int      ep;
    sfp      lr;
    act_func f;
    bit      clr_first;
    int      inj;
    int      exp_conv;
    int      exp_run;
    bit      truth;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference arithmetic: Q8.8 two's complement, results truncated to 16 bits.
  function automatic sfp m_mul(input sfp a, input sfp b);
    int p;
    p = int'(a) * int'(b);
    return sfp'(p >>> SFP_FRAC);
  endfunction

  function automatic sfp m_act(input act_func f, input sfp x);
    if (f == ACT_STEP) return (x > 0) ? SFP_ONE : sfp'(0);
    if (f == ACT_RELU) return (x < 0) ? sfp'(0) : x;
    return x;
  endfunction

  function automatic sfp m_dot(input int j, input sfp [SIZE-1:0] v);
    int acc;
    acc = int'(mb[j]);
    for (int i = 0; i < SIZE; i++) begin
      sfp vi;
      vi = v[i];
      acc += int'(m_mul(mw[j][i], vi));
    end
    return sfp'(acc);
  endfunction

  task automatic model_clear();
    for (int j = 0; j < OUTPUTS; j++) begin
      mb[j] = '0;
      for (int i = 0; i < SIZE; i++) mw[j][i] = '0;
    end
  endtask

  task automatic model_train(input int ep, input sfp lr, input act_func f, output int run, output bit conv);
    run = 0;
    conv = 0;
    for (int e = 0; e < ep; e++) begin
      int errs;
      errs = 0;
      for (int s = 0; s < NUM; s++) begin
        for (int j = 0; j < OUTPUTS; j++) begin
          sfp y, t, err, d;
          y = m_act(f, m_dot(j, train_values[s]));
          t = expected[s][j];
          err = sfp'(int'(t) - int'(y));
          if (err != 0) errs++;
          d = m_mul(lr, err);
          for (int i = 0; i < SIZE; i++) begin
            sfp xi;
            xi = train_values[s][i];
            mw[j][i] = sfp'(int'(mw[j][i]) + int'(m_mul(d, xi)));
          end
          mb[j] = sfp'(int'(mb[j]) + int'(d));
        end
      end
      run++;
      if (errs == 0) begin
        conv = 1;
        break;
      end
    end
  endtask

  task automatic set_data(input int kind);
    for (int s = 0; s < NUM; s++) begin
      logic [1:0] sb;
      sb = 2'(s);
      if (kind == 2) begin
        for (int i = 0; i < SIZE; i++) train_values[s][i] = sfp'(int'($urandom_range(0, 1024)) - 512);
        for (int j = 0; j < OUTPUTS; j++) expected[s][j] = $urandom_range(0, 1) ? SFP_ONE : sfp'(0);
      end else begin
        train_values[s][0] = sb[1] ? SFP_ONE : sfp'(0);
        train_values[s][1] = sb[0] ? SFP_ONE : sfp'(0);
        if (kind == 0) begin
          expected[s][0] = (sb[1] & sb[0]) ? SFP_ONE : sfp'(0);
          expected[s][1] = (sb[1] | sb[0]) ? SFP_ONE : sfp'(0);
        end else begin
          expected[s][0] = (sb[1] ^ sb[0]) ? SFP_ONE : sfp'(0);
          expected[s][1] = (sb[1] ^ sb[0]) ? SFP_ONE : sfp'(0);
        end
      end
    end
  endtask

  task automatic do_clear();
    clear_weights = 1'b1;
    tick();
    clear_weights = 1'b0;
    model_clear();
  endtask

  task automatic chk_pred(input string name);
    #1;
    for (int j = 0; j < OUTPUTS; j++) begin
      sfp p;
      p = prediction[j];
      chk($sformatf("%s_pred%0d", name, j), p, m_act(activation, m_dot(j, values)));
    end
  endtask

  task automatic run_and_check(input string name, input int ep, input sfp lr, input act_func f, input int inj_k);
    int m_run, lat, first_done, n_done, busy_bad;
    bit m_conv;
    model_train(ep, lr, f, m_run, m_conv);
    lat = m_run * LEN + 1;
    epochs = 16'(ep);
    learning_rate = lr;
    activation = f;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_done = -1;
    n_done = 0;
    busy_bad = (busy !== 1'b0) ? 1 : 0;
    for (int k = 1; k <= lat + 3; k++) begin
      if (k == inj_k) begin
        start = 1'b1;
        clear_weights = 1'b1;
      end
      tick();
      start = 1'b0;
      clear_weights = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (busy !== logic'(k < lat)) busy_bad++;
    end
    chk({name, "_done_latency"}, first_done, lat);
    chk({name, "_done_pulses"}, n_done, 1);
    chk({name, "_busy_errs"}, busy_bad, 0);
    chk({name, "_epochs_run"}, epochs_run, m_run);
    chk({name, "_converged"}, converged, m_conv);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < SIZE; i++) values[i] = sfp'(int'($urandom_range(0, 1024)) - 512);
      chk_pred($sformatf("%s_rand%0d", name, r));
    end
  endtask

  task automatic chk_truth(input string name);
    for (int s = 0; s < NUM; s++) begin
      logic [1:0] sb;
      sfp p0, p1;
      sb = 2'(s);
      values[0] = sb[1] ? SFP_ONE : sfp'(0);
      values[1] = sb[0] ? SFP_ONE : sfp'(0);
      #1;
      p0 = prediction[0];
      p1 = prediction[1];
      chk($sformatf("%s_and_%0d", name, s), p0, (sb[1] & sb[0]) ? SFP_ONE : sfp'(0));
      chk($sformatf("%s_or_%0d", name, s), p1, (sb[1] | sb[0]) ? SFP_ONE : sfp'(0));
    end
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{kind: 0, ep: 1,  lr: SFP_ONE,  f: ACT_STEP, clr_first: 1, inj: 0, exp_conv: 0, exp_run: 1,  truth: 0};
    tbl[1] = '{kind: 0, ep: 50, lr: 16'sh0080, f: ACT_STEP, clr_first: 1, inj: 0, exp_conv: 1, exp_run: -1, truth: 1};
    tbl[2] = '{kind: 0, ep: 0,  lr: SFP_ONE,  f: ACT_STEP, clr_first: 0, inj: 0, exp_conv: 0, exp_run: 0,  truth: 1};
    tbl[3] = '{kind: 1, ep: 10, lr: SFP_ONE,  f: ACT_STEP, clr_first: 1, inj: 0, exp_conv: 0, exp_run: 10, truth: 0};
    tbl[4] = '{kind: 0, ep: 50, lr: 16'sh0040, f: ACT_STEP, clr_first: 1, inj: 5, exp_conv: 1, exp_run: -1, truth: 1};

    rst_n = 1'b0;
    start = 1'b0;
    clear_weights = 1'b0;
    epochs = '0;
    learning_rate = '0;
    activation = ACT_STEP;
    values = '0;
    train_values = '0;
    expected = '0;
    model_clear();
    repeat (2) tick();

    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_converged", converged, 0);
    chk("reset_epochs_run", epochs_run, 0);
    values[0] = SFP_ONE;
    values[1] = SFP_ONE;
    chk_pred("reset");
    rst_n = 1'b1;
    tick();

    // Clear and start together: the clear wins and no run begins.
    set_data(0);
    epochs = 16'd5;
    clear_weights = 1'b1;
    start = 1'b1;
    tick();
    clear_weights = 1'b0;
    start = 1'b0;
    tick();
    chk("clr_start_busy", busy, 0);
    chk("clr_start_done", done, 0);

    for (int v = 0; v < 5; v++) begin
      string nm;
      nm = $sformatf("tbl%0d", v);
      if (tbl[v].clr_first) do_clear();
      set_data(tbl[v].kind);
      run_and_check(nm, tbl[v].ep, tbl[v].lr, tbl[v].f, tbl[v].inj);
      if (tbl[v].exp_conv >= 0) chk({nm, "_conv_const"}, converged, tbl[v].exp_conv);
      if (tbl[v].exp_run >= 0) chk({nm, "_run_const"}, epochs_run, tbl[v].exp_run);
      if (tbl[v].exp_conv == 1) chk({nm, "_run_below_max"}, (epochs_run < 16'(tbl[v].ep)) ? 1 : 0, 1);
      if (tbl[v].truth) chk_truth(nm);
    end

    // Clearing after a finished run returns every output to act(0).
    clear_weights = 1'b1;
    tick();
    clear_weights = 1'b0;
    values[0] = SFP_ONE;
    values[1] = SFP_ONE;
    #1;
    for (int j = 0; j < OUTPUTS; j++) begin
      sfp p;
      p = prediction[j];
      chk($sformatf("post_clear_pred%0d", j), p, 0);
    end
    model_clear();

    // Reset in the middle of a MAC aborts the run and wipes the weights.
    set_data(0);
    epochs = 16'd50;
    learning_rate = 16'sh0080;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_epochs_run", epochs_run, 0);
    for (int j = 0; j < OUTPUTS; j++) begin
      sfp p;
      p = prediction[j];
      chk($sformatf("midreset_pred%0d", j), p, 0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    model_clear();
    run_and_check("after_reset", 3, SFP_ONE, ACT_STEP, 0);

    for (int r = 0; r < 6; r++) begin
      act_func f;
      sfp lr;
      int ep;
      if ($urandom_range(0, 1) == 1) do_clear();
      set_data(2);
      f = act_func'(2'($urandom_range(0, 2)));
      lr = sfp'(32 << $urandom_range(0, 2));
      ep = int'($urandom_range(1, 5));
      run_and_check($sformatf("rand%0d", r), ep, lr, f, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
